lcd_timing_ctrl: RTL
====================

Name: lcd_timing_ctrl

Overview:
- Sequences the LCD controller: runs the dot counter, the line counter (LY) and the PPU mode state machine.
- Produces the LY value read back at FF44, LY==LYC coincidence, the STAT mode bits, and the VBLANK and STAT interrupt requests.
- Consumes LCDC.7 (FF40) and LYC (FF45) from the video register block, and the STAT interrupt selects from FF41.
- Gates the pixel fetcher through mode outputs.

Parameters:
- DOTS_PER_LINE, 456, dots per scanline, one dot per clk.
- VISIBLE_LINES, 144, lines 0..143 are active.
- TOTAL_LINES, 154, LY wraps after TOTAL_LINES-1.
- OAM_DOTS, 80, length of mode 2.
- MODE3_MAX, 289, maximum mode 3 length in dots (timeout).

Ports:
- clk  in  1  dot clock
- nreset  in  1  synchronous, active-low reset
- lcd_en  in  1  LCDC bit 7 (ff40_d7)
- lyc  in  8  FF45 value (ff45_d7..d0)
- stat_sel  in  4  FF41 bits 6..3: [3]=LYC, [2]=mode2, [1]=mode1, [0]=mode0 interrupt selects
- pix_done  in  1  one-cycle pulse from the pixel pipe: last pixel of the line pushed
- ly  out  8  current line, drives v[7:0] for FF44 reads
- dot  out  9  dot index within the line
- mode  out  2  0=HBLANK, 1=VBLANK, 2=OAM, 3=XFER
- coinc  out  1  registered LY==LYC flag (STAT bit 2)
- line_start  out  1  one-cycle pulse at dot 0 of each line
- vblank_irq  out  1  one-cycle request pulse
- stat_irq  out  1  one-cycle request pulse

Behaviour:
- Reset (nreset=0 sampled at a clk edge): dot=0, ly=0, mode=0, coinc=0, all pulses 0, stat_line history=0.
- lcd_en=0 behaves exactly as reset except coinc, which tracks (0==lyc).
  - No IRQs while disabled; the held stat_line is forced 0.
- First cycle with lcd_en=1: dot=0, ly=0, mode=2, line_start=1.
- dot increments every cycle. At DOTS_PER_LINE-1 it wraps to 0 and ly increments. At ly=TOTAL_LINES-1 the wrap goes to 0.
- Mode FSM, ly < VISIBLE_LINES:
  - OAM for dot 0..OAM_DOTS-1.
  - XFER from dot OAM_DOTS.
  - XFER -> HBLANK on the cycle after pix_done=1, or when dot reaches OAM_DOTS+MODE3_MAX, whichever comes first.
  - pix_done outside XFER is ignored.
  - HBLANK until line wrap.
- Mode for ly >= VISIBLE_LINES is VBLANK for all dots.
- Mode transitions take effect on the same edge as the dot/ly change that causes them.
- vblank_irq=1 for exactly the one cycle where ly becomes VISIBLE_LINES (dot 0).
- coinc is registered: updated every cycle from the next ly value, so it is valid in the same cycle ly changes.
  - An lyc write is reflected one cycle later.
- stat_line = (sel[3]&coinc) | (sel[2]&mode==2) | (sel[1]&mode==1) | (sel[0]&mode==0).
  - stat_irq pulses one cycle on each 0->1 transition of stat_line.
  - If stat_line stays high across sources (e.g. HBLANK then OAM with both selects set), no second pulse is issued (STAT blocking).
  - If vblank and mode1-select rise together, both irqs pulse.
- Reset or lcd_en fall mid-line aborts immediately; no pulse is emitted that cycle.
- line_start=1 at dot 0 of every line, including VBLANK lines.

Decomposition:
- Package lcd_timing_pkg holds:
  - the mode enum (MODE_HBLANK=0, MODE_VBLANK=1, MODE_OAM=2, MODE_XFER=3);
  - the default timing constants;
  - the stat_sel bit index constants.
- Sub-module lcd_stat_irq: combines stat_sel, mode and coinc into stat_line, then edge-detects it into stat_irq. It has its own clk/nreset and is cleared by lcd_en=0.

Test Plan:
- Reset release with lcd_en=1, pix_done held at dot 252 -> ly=0, mode=2 for dots 0..79, mode=3 for dots 80..252, mode=0 from dot 253, ly=1 at cycle 456.
- pix_done never asserted -> mode 3 ends at dot 369 (80+289).
- Run to ly=144 -> vblank_irq single pulse at cycle 144*456, mode=1 through ly=153, ly=0 mode=2 at cycle 154*456.
- lyc=5, stat_sel=4'b1000 -> coinc=1 for all of line 5, one stat_irq at ly 5 dot 0; write lyc=5 while ly=5 already set -> irq one cycle after the write.
- stat_sel=4'b0101 -> stat_irq at each HBLANK start; no extra pulse at the HBLANK->OAM boundary; pulse again at the next HBLANK.
- lcd_en dropped at ly=70 dot 100 -> next cycle ly=0, mode=0, no irqs; re-enable -> line_start, mode=2, dot=0.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: PPU mode encoding, default LCD timing and STAT select bit positions
package lcd_timing_pkg;
  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } mode_e;
  localparam int DEF_DOTS_PER_LINE = 456;
  localparam int DEF_VISIBLE_LINES = 144;
  localparam int DEF_TOTAL_LINES   = 154;
  localparam int DEF_OAM_DOTS      = 80;
  localparam int DEF_MODE3_MAX     = 289;
  localparam int SEL_HBLANK = 0;
  localparam int SEL_VBLANK = 1;
  localparam int SEL_OAM    = 2;
  localparam int SEL_LYC    = 3;
endpackage

// File: rtl/lcd_stat_irq.sv
// lcd_stat_irq: combines STAT sources into stat_line and pulses o_stat_irq on its rising edge
module lcd_stat_irq
  import lcd_timing_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_nreset,
  input  logic       i_lcd_en,
  input  logic [3:0] i_stat_sel,
  input  logic [1:0] i_mode,
  input  logic       i_coinc,
  output logic       o_stat_irq
);
  logic w_line;
  logic r_line;
  logic r_irq;
  // Inputs are next-state values, so the pulse lines up with the mode/coinc change
  always_comb begin
    w_line = (i_stat_sel[SEL_LYC] & i_coinc) |
             (i_stat_sel[SEL_OAM] & (i_mode == MODE_OAM)) |
             (i_stat_sel[SEL_VBLANK] & (i_mode == MODE_VBLANK)) |
             (i_stat_sel[SEL_HBLANK] & (i_mode == MODE_HBLANK));
  end
  always_ff @(posedge i_clk) begin
    if (!i_nreset || !i_lcd_en) begin
      r_line <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_line <= w_line;
      r_irq  <= w_line & ~r_line;
    end
  end
  assign o_stat_irq = r_irq;
endmodule

// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: dot/line counters, PPU mode FSM, LY==LYC coincidence and LCD interrupt requests
module lcd_timing_ctrl
  import lcd_timing_pkg::*;
#(
  parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
  parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
  parameter int TOTAL_LINES   = DEF_TOTAL_LINES,
  parameter int OAM_DOTS      = DEF_OAM_DOTS,
  parameter int MODE3_MAX     = DEF_MODE3_MAX
) (
  input  logic       i_clk,
  input  logic       i_nreset,
  input  logic       i_lcd_en,
  input  logic [7:0] i_lyc,
  input  logic [3:0] i_stat_sel,
  input  logic       i_pix_done,
  output logic [7:0] o_ly,
  output logic [8:0] o_dot,
  output logic [1:0] o_mode,
  output logic       o_coinc,
  output logic       o_line_start,
  output logic       o_vblank_irq,
  output logic       o_stat_irq
);
  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] XFER_DOT  = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + MODE3_MAX);
  localparam logic [7:0] LAST_LINE = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);
  logic       r_on;
  logic [8:0] r_dot;
  logic [7:0] r_ly;
  mode_e      r_mode;
  logic       r_coinc;
  logic       r_line_start;
  logic       r_vblank_irq;
  logic       w_wrap;
  logic [8:0] w_dot_n;
  logic [7:0] w_ly_n;
  mode_e      w_mode_n;
  logic       w_coinc_n;
  logic       w_line_start_n;
  logic       w_vblank_n;
  // r_on low means the next enabled cycle is the first one: start line 0 in OAM
  always_comb begin
    w_wrap         = r_dot == LAST_DOT;
    w_dot_n        = '0;
    w_ly_n         = '0;
    w_mode_n       = MODE_HBLANK;
    w_line_start_n = 1'b0;
    w_vblank_n     = 1'b0;
    if (i_lcd_en && !r_on) begin
      w_mode_n       = MODE_OAM;
      w_line_start_n = 1'b1;
    end else if (i_lcd_en) begin
      w_dot_n        = w_wrap ? '0 : r_dot + 9'd1;
      w_ly_n         = !w_wrap ? r_ly : (r_ly == LAST_LINE ? '0 : r_ly + 8'd1);
      w_line_start_n = w_wrap;
      w_vblank_n     = w_wrap && (w_ly_n == VIS_LINES);
      w_mode_n       = (w_ly_n >= VIS_LINES) ? MODE_VBLANK :
                       (w_dot_n < XFER_DOT) ? MODE_OAM :
                       (w_dot_n == XFER_DOT) ? MODE_XFER :
                       (r_mode == MODE_XFER && !i_pix_done && w_dot_n != XFER_END) ? MODE_XFER :
                       MODE_HBLANK;
    end
    w_coinc_n = w_ly_n == i_lyc;
  end
  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_on         <= 1'b0;
      r_dot        <= '0;
      r_ly         <= '0;
      r_mode       <= MODE_HBLANK;
      r_coinc      <= 1'b0;
      r_line_start <= 1'b0;
      r_vblank_irq <= 1'b0;
    end else begin
      r_on         <= i_lcd_en;
      r_dot        <= w_dot_n;
      r_ly         <= w_ly_n;
      r_mode       <= w_mode_n;
      r_coinc      <= w_coinc_n;
      r_line_start <= w_line_start_n;
      r_vblank_irq <= w_vblank_n;
    end
  end
  lcd_stat_irq u_stat_irq (
    .i_clk      (i_clk),
    .i_nreset   (i_nreset),
    .i_lcd_en   (i_lcd_en),
    .i_stat_sel (i_stat_sel),
    .i_mode     (w_mode_n),
    .i_coinc    (w_coinc_n),
    .o_stat_irq (o_stat_irq)
  );
  assign o_ly         = r_ly;
  assign o_dot        = r_dot;
  assign o_mode       = r_mode;
  assign o_coinc      = r_coinc;
  assign o_line_start = r_line_start;
  assign o_vblank_irq = r_vblank_irq;
endmodule
